// File: rtl/bcd_digit_entry.sv
// Collects up to four ASCII decimal digits into packed BCD and launches the BCD-to-binary converter.
// Optional: define BACKSPACE_EN to let 0x08 remove the most recently entered digit.
module bcd_digit_entry #(
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter logic [7:0] CLR_CHAR  = 8'h1B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       conv_ready,
  input  logic       conv_done_tick,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       start,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       err_tick
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_digits;
  logic [15:0] w_digits_nxt;
  logic [2:0]  r_count;
  logic [2:0]  w_count_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic        w_is_digit;

  assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_COLLECT;
      r_digits <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_count  <= w_count_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_count_nxt  = r_count;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (rx_done_tick) begin
          if (w_is_digit) begin
            if (r_count < 3'd4) begin
              w_digits_nxt = {r_digits[11:0], rx_data[3:0]};
              w_count_nxt  = r_count + 3'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (rx_data == TERM_CHAR) begin
            if (r_count != 3'd0) w_state_nxt = S_LAUNCH;
          end else if (rx_data == CLR_CHAR) begin
            w_digits_nxt = '0;
            w_count_nxt  = '0;
`ifdef BACKSPACE_EN
          end else if (rx_data == 8'h08) begin
            if (r_count != 3'd0) begin
              w_digits_nxt = {4'h0, r_digits[15:4]};
              w_count_nxt  = r_count - 3'd1;
            end
`endif
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (rx_done_tick) w_err_nxt = 1'b1;
        if (conv_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Digits stay frozen here; the converter samples them throughout its run.
        if (rx_done_tick) w_err_nxt = 1'b1;
        if (conv_done_tick) begin
          w_digits_nxt = '0;
          w_count_nxt  = '0;
          w_state_nxt  = S_COLLECT;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // Combinational from state so the async reset removes a pending start immediately.
  assign start       = (r_state == S_LAUNCH) && conv_ready;
  assign busy        = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign bcd3        = r_digits[15:12];
  assign bcd2        = r_digits[11:8];
  assign bcd1        = r_digits[7:4];
  assign bcd0        = r_digits[3:0];
  assign digit_count = r_count;
  assign err_tick    = r_err;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed vector table plus hand-written reset sequences for bcd_digit_entry.
module tb_bcd_digit_entry;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       conv_ready;
  logic       conv_done_tick;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic       start;
  logic       busy;
  logic [2:0] digit_count;
  logic       err_tick;

  int total = 0;
  int bad   = 0;

  bcd_digit_entry #(.TERM_CHAR(8'h0D), .CLR_CHAR(8'h1B)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_done_tick   (rx_done_tick),
    .conv_ready     (conv_ready),
    .conv_done_tick (conv_done_tick),
    .bcd3           (bcd3),
    .bcd2           (bcd2),
    .bcd1           (bcd1),
    .bcd0           (bcd0),
    .start          (start),
    .busy           (busy),
    .digit_count    (digit_count),
    .err_tick       (err_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_start is sampled before the edge (it is combinational); the rest after the edge.
  typedef struct {
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic        done;
    logic        exp_start;
    logic [15:0] exp_dig;
    logic [2:0]  exp_cnt;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic dn, logic st,
                              logic [15:0] dig, logic [2:0] c, logic b, logic e);
    vec_t x;
    x.vld = v; x.data = d; x.rdy = r; x.done = dn; x.exp_start = st;
    x.exp_dig = dig; x.exp_cnt = c; x.exp_busy = b; x.exp_err = e;
    return x;
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(string tag, int idx, logic [15:0] dig, logic [2:0] c,
                           logic st, logic b, logic e);
    check({tag, ".digits"}, idx, {bcd3, bcd2, bcd1, bcd0}, dig);
    check({tag, ".count"},  idx, 16'(digit_count), 16'(c));
    check({tag, ".start"},  idx, 16'(start), 16'(st));
    check({tag, ".busy"},   idx, 16'(busy), 16'(b));
    check({tag, ".err"},    idx, 16'(err_tick), 16'(e));
  endtask

  task automatic send(logic [7:0] d);
    rx_data = d; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] BS  = 8'h08;

  initial begin
    rx_data = '0; rx_done_tick = 1'b0; conv_ready = 1'b1; conv_done_tick = 1'b0;
    reset = 1'b1;
    #2;
    check_all("reset_async", 0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset", 0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    //             vld  data   rdy  done st    digits    cnt  busy err
    // '9','9','9',CR, launch, wait, done
    vecs.push_back(mk(1, 8'h39, 1, 0, 0, 16'h0009, 3'd1, 0, 0));
    vecs.push_back(mk(1, 8'h39, 1, 0, 0, 16'h0099, 3'd2, 0, 0));
    vecs.push_back(mk(1, 8'h39, 1, 0, 0, 16'h0999, 3'd3, 0, 0));
    vecs.push_back(mk(1, CR,    1, 0, 0, 16'h0999, 3'd3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 16'h0999, 3'd3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0999, 3'd3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 16'h0000, 3'd0, 0, 0));
    // five digits, overflow, clear
    vecs.push_back(mk(1, 8'h31, 1, 0, 0, 16'h0001, 3'd1, 0, 0));
    vecs.push_back(mk(1, 8'h32, 1, 0, 0, 16'h0012, 3'd2, 0, 0));
    vecs.push_back(mk(1, 8'h33, 1, 0, 0, 16'h0123, 3'd3, 0, 0));
    vecs.push_back(mk(1, 8'h34, 1, 0, 0, 16'h1234, 3'd4, 0, 0));
    vecs.push_back(mk(1, 8'h35, 1, 0, 0, 16'h1234, 3'd4, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h1234, 3'd4, 0, 0));
    vecs.push_back(mk(1, ESC,   1, 0, 0, 16'h0000, 3'd0, 0, 0));
    // CR on empty, invalid byte
    vecs.push_back(mk(1, CR,    1, 0, 0, 16'h0000, 3'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0, 0));
    vecs.push_back(mk(1, 8'h41, 1, 0, 0, 16'h0000, 3'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0, 0));
    // '7',CR with converter not ready for 5 cycles
    vecs.push_back(mk(1, 8'h37, 0, 0, 0, 16'h0007, 3'd1, 0, 0));
    vecs.push_back(mk(1, CR,    0, 0, 0, 16'h0007, 3'd1, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 16'h0007, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 16'h0007, 3'd1, 1, 0));
    vecs.push_back(mk(1, 8'h33, 1, 0, 0, 16'h0007, 3'd1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0007, 3'd1, 1, 0));
    vecs.push_back(mk(1, CR,    1, 0, 0, 16'h0007, 3'd1, 1, 1));
    // rx coinciding with conv_done: byte rejected, entry still cleared
    vecs.push_back(mk(1, 8'h35, 1, 1, 0, 16'h0000, 3'd0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0, 0));
    // conv_done in collect ignored
    vecs.push_back(mk(1, 8'h38, 1, 0, 0, 16'h0008, 3'd1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 16'h0008, 3'd1, 0, 0));
    vecs.push_back(mk(1, ESC,   1, 0, 0, 16'h0000, 3'd0, 0, 0));
    // backspace
    vecs.push_back(mk(1, 8'h31, 1, 0, 0, 16'h0001, 3'd1, 0, 0));
    vecs.push_back(mk(1, 8'h32, 1, 0, 0, 16'h0012, 3'd2, 0, 0));
    vecs.push_back(mk(1, 8'h33, 1, 0, 0, 16'h0123, 3'd3, 0, 0));
`ifdef BACKSPACE_EN
    vecs.push_back(mk(1, BS,    1, 0, 0, 16'h0012, 3'd2, 0, 0));
`else
    vecs.push_back(mk(1, BS,    1, 0, 0, 16'h0123, 3'd3, 0, 1));
`endif
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, vecs[vecs.size()-1].exp_dig,
                      vecs[vecs.size()-1].exp_cnt, 0, 0));
    vecs.push_back(mk(1, ESC,   1, 0, 0, 16'h0000, 3'd0, 0, 0));
`ifdef BACKSPACE_EN
    vecs.push_back(mk(1, BS,    1, 0, 0, 16'h0000, 3'd0, 0, 0));
`else
    vecs.push_back(mk(1, BS,    1, 0, 0, 16'h0000, 3'd0, 0, 1));
`endif
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0, 0));

    foreach (vecs[i]) begin
      rx_data        = vecs[i].data;
      rx_done_tick   = vecs[i].vld;
      conv_ready     = vecs[i].rdy;
      conv_done_tick = vecs[i].done;
      #2;
      check("vec.start_pre", i, 16'(start), 16'(vecs[i].exp_start));
      @(posedge clk); #1;
      check("vec.digits", i, {bcd3, bcd2, bcd1, bcd0}, vecs[i].exp_dig);
      check("vec.count",  i, 16'(digit_count), 16'(vecs[i].exp_cnt));
      check("vec.busy",   i, 16'(busy), 16'(vecs[i].exp_busy));
      check("vec.err",    i, 16'(err_tick), 16'(vecs[i].exp_err));
    end
    rx_done_tick = 1'b0; conv_done_tick = 1'b0; conv_ready = 1'b1;

    // Reset while in launch with start asserted: start must drop without a clock edge
    send(8'h34); send(8'h32); send(CR);
    check("launch.start_hi", 1, 16'(start), 16'd1);
    #2 reset = 1'b1;
    #1;
    check_all("rst_launch", 1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst1", 1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset during wait
    send(8'h34); send(8'h32); send(CR);
    @(posedge clk); #1;
    check_all("in_wait", 2, 16'h0042, 3'd2, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all("rst_wait", 2, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst2", 2, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    send(8'h35);
    check_all("new_entry", 3, 16'h0005, 3'd1, 1'b0, 1'b0, 1'b0);
    send(8'h36);
    check_all("new_entry", 4, 16'h0056, 3'd2, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
